// File: rtl/vjtag_bus_cmd_ctrl.sv
// Virtual JTAG command sequencer: IR decode, DR shift, single-beat bus requests.
// Optional: define VJTAG_ADDR_AUTOINC_EN to step addr_reg by 4 per transaction.
module vjtag_bus_cmd_ctrl #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int IRW = 8
) (
    input  logic           tck,
    input  logic           rst_n,
    input  logic [IRW-1:0] ir_in,
    input  logic           virtual_state_cdr,
    input  logic           virtual_state_sdr,
    input  logic           virtual_state_udr,
    input  logic           tdi,
    output logic           tdo,
    output logic [IRW-1:0] ir_out,
    output logic           req_valid,
    input  logic           req_ready,
    output logic           req_we,
    output logic [AW-1:0]  req_addr,
    output logic [DW-1:0]  req_wdata,
    input  logic           rsp_valid,
    input  logic [DW-1:0]  rsp_rdata,
    input  logic           rsp_err
);

    localparam logic [IRW-1:0] OP_ADDR   = IRW'(1);
    localparam logic [IRW-1:0] OP_WRITE  = IRW'(2);
    localparam logic [IRW-1:0] OP_READ   = IRW'(3);
    localparam logic [IRW-1:0] OP_STATUS = IRW'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] sr_q, sr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          bypass_q, bypass_d;
    logic          req_valid_q, req_valid_d;
    logic          req_we_q, req_we_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0] req_wdata_q, req_wdata_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;

    logic is_addr, is_write, is_read, is_status, is_bypass;
    logic launch, done;

    assign is_addr   = (ir_in == OP_ADDR);
    assign is_write  = (ir_in == OP_WRITE);
    assign is_read   = (ir_in == OP_READ);
    assign is_status = (ir_in == OP_STATUS);
    assign is_bypass = !(is_addr || is_write || is_read || is_status);

    assign launch = virtual_state_udr && (is_write || is_read);
    assign done   = (state_q == S_WAIT) && rsp_valid;

    // FSM state register
    always_ff @(posedge tck) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; rsp_valid only counts once the request was accepted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (launch)    state_d = S_REQ;
            S_REQ:   if (req_ready) state_d = S_WAIT;
            S_WAIT:  if (rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered bus outputs
    always_comb begin
        sr_d        = sr_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        bypass_d    = bypass_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        busy_d      = busy_q;
        err_d       = err_q;
        ovr_d       = ovr_q;

        if (virtual_state_cdr) begin
            unique case (1'b1)
                is_addr:   sr_d = DW'(addr_q);
                is_write:  sr_d = '0;
                is_read:   sr_d = rdata_q;
                is_status: sr_d = DW'({ovr_q, err_q, busy_q});
                is_bypass: bypass_d = 1'b0;
            endcase
        end else if (virtual_state_sdr) begin
            if (is_bypass) bypass_d = tdi;
            else           sr_d = {tdi, sr_q[DW-1:1]};
        end

        // A clear in the same cycle as a failing response keeps the new error
        if (virtual_state_udr && is_status && sr_q[0]) begin
            err_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (launch) begin
            if (state_q == S_IDLE) begin
                req_valid_d = 1'b1;
                req_we_d    = is_write;
                req_addr_d  = addr_q;
                req_wdata_d = sr_q;
                busy_d      = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (state_q == S_REQ && req_ready) req_valid_d = 1'b0;

        if (done) begin
            if (!req_we_q) rdata_d = rsp_rdata;
            err_d  = err_d | rsp_err;
            busy_d = 1'b0;
`ifdef VJTAG_ADDR_AUTOINC_EN
            addr_d = addr_q + AW'(4);
`endif
        end

        // Explicit address load wins over the post-transaction step
        if (virtual_state_udr && is_addr) addr_d = sr_q[AW-1:0];
    end

    // Datapath registers
    always_ff @(posedge tck) begin
        if (!rst_n) begin
            sr_q        <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            bypass_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            bypass_q    <= bypass_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign tdo       = is_bypass ? bypass_q : sr_q[0];
    assign ir_out    = IRW'({state_q == S_WAIT, ovr_q, err_q, busy_q});
    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;

endmodule

// File: tb/tb_vjtag_bus_cmd_ctrl.sv
// Bench for vjtag_bus_cmd_ctrl: JTAG scan tasks, bus responder,
// transaction-level reference model and per-cycle output compare.
module tb_vjtag_bus_cmd_ctrl;

    logic        tck = 1'b0;
    logic        rst_n;
    logic [7:0]  ir_in;
    logic        virtual_state_cdr, virtual_state_sdr, virtual_state_udr;
    logic        tdi, tdo;
    logic [7:0]  ir_out;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    vjtag_bus_cmd_ctrl dut (
        .tck(tck), .rst_n(rst_n), .ir_in(ir_in),
        .virtual_state_cdr(virtual_state_cdr),
        .virtual_state_sdr(virtual_state_sdr),
        .virtual_state_udr(virtual_state_udr),
        .tdi(tdi), .tdo(tdo), .ir_out(ir_out),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 tck = ~tck;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) -------------
    int          m_phase;   // 0 no transaction, 1 request offered, 2 awaiting response
    logic [31:0] m_sr, m_cap, m_addr, m_rdata, m_raddr, m_wdata;
    logic        m_byp, m_err, m_ovr, m_we;

    always @(posedge tck) begin : model
        logic done, launch, is_cmd;
        int   nph;
        is_cmd = (ir_in >= 8'd1) && (ir_in <= 8'd4);
        if (!rst_n) begin
            m_phase = 0; m_sr = 0; m_cap = 0; m_addr = 0; m_rdata = 0;
            m_raddr = 0; m_wdata = 0; m_byp = 0; m_err = 0; m_ovr = 0;
            m_we = 0;
        end else begin
            done   = (m_phase == 2) && rsp_valid;
            launch = virtual_state_udr && (ir_in == 8'd2 || ir_in == 8'd3);
            if (virtual_state_cdr) begin
                case (ir_in)
                    8'd1:    m_sr = m_addr;
                    8'd2:    m_sr = 0;
                    8'd3:    m_sr = m_rdata;
                    8'd4:    m_sr = {29'd0, m_ovr, m_err, m_phase != 0};
                    default: m_byp = 0;
                endcase
                if (is_cmd) m_cap = m_sr;
            end else if (virtual_state_sdr) begin
                if (is_cmd) m_sr = {tdi, m_sr[31:1]};
                else        m_byp = tdi;
            end
            nph = m_phase;
            if (virtual_state_udr && ir_in == 8'd4 && m_sr[0]) begin
                m_err = 0; m_ovr = 0;
            end
            if (launch) begin
                if (m_phase == 0) begin
                    nph = 1; m_we = (ir_in == 8'd2);
                    m_raddr = m_addr; m_wdata = m_sr;
                end else m_ovr = 1;
            end
            if (m_phase == 1 && req_ready) nph = 2;
            if (done) begin
                nph = 0;
                if (!m_we) m_rdata = rsp_rdata;
                if (rsp_err) m_err = 1;
`ifdef VJTAG_ADDR_AUTOINC_EN
                m_addr = m_addr + 32'd4;
`endif
            end
            if (virtual_state_udr && ir_in == 8'd1) m_addr = m_sr;
            m_phase = nph;
        end
    end

    // ---------------- per-cycle compare --------------------------------
    always @(negedge tck) begin
        if (chk_en) begin
            chk("ir_out", {24'd0, ir_out},
                {28'd0, m_phase == 2, m_ovr, m_err, m_phase != 0});
            chk("req_valid", {31'd0, req_valid}, {31'd0, m_phase == 1});
            if (m_phase == 1) begin
                chk("req_we", {31'd0, req_we}, {31'd0, m_we});
                chk("req_addr", req_addr, m_raddr);
                chk("req_wdata", req_wdata, m_wdata);
            end
        end
    end

    // ---------------- request monitor ----------------------------------
    int   n_pulse = 0, n_vcyc = 0;
    logic rv_prev = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;
    always @(negedge tck) begin
        if (req_valid === 1'b1) begin
            if (!rv_prev) n_pulse++;
            n_vcyc++;
            seen_addr = req_addr; seen_wdata = req_wdata; seen_we = req_we;
        end
        rv_prev = (req_valid === 1'b1);
    end

    // ---------------- bus responder ------------------------------------
    bit          bus_en = 1;
    int          ready_lat = 0, rsp_lat = 3;
    logic [31:0] rsp_data_v = 0;
    logic        rsp_err_v = 0;
    int          r_st = 0, r_cnt = 0;
    always @(negedge tck) begin
        if (bus_en) begin
            rsp_valid = 1'b0;
            if (r_st == 0) begin
                req_ready = 1'b0;
                if (req_valid === 1'b1) begin
                    if (r_cnt == ready_lat) begin
                        req_ready = 1'b1; r_st = 1; r_cnt = 0;
                    end else r_cnt++;
                end
            end else begin
                req_ready = 1'b0;
                r_cnt++;
                if (r_cnt >= rsp_lat) begin
                    rsp_valid = 1'b1; rsp_rdata = rsp_data_v;
                    rsp_err = rsp_err_v; r_st = 0; r_cnt = 0;
                end
            end
        end
    end

    // ---------------- scan helpers -------------------------------------
    task automatic scan(input logic [7:0] op, input logic [31:0] din,
                        output logic [31:0] dout);
        ir_in = op;
        virtual_state_cdr = 1; @(negedge tck);
        virtual_state_cdr = 0; virtual_state_sdr = 1;
        for (int i = 0; i < 32; i++) begin
            dout[i] = tdo; tdi = din[i]; @(negedge tck);
        end
        virtual_state_sdr = 0; tdi = 0;
        if (op >= 8'd1 && op <= 8'd4) chk("scan_vs_model", dout, m_cap);
        virtual_state_udr = 1; @(negedge tck);
        virtual_state_udr = 0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && ir_out[0] !== 1'b0; i++) @(negedge tck);
        chk("idle_timeout", {31'd0, ir_out[0]}, 32'd0);
    endtask

    logic [31:0] d;

    initial begin
        rst_n = 0; ir_in = 0; tdi = 0;
        virtual_state_cdr = 0; virtual_state_sdr = 0; virtual_state_udr = 0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
        @(negedge tck); @(negedge tck);
        chk_en = 1;
        chk("rst_ir_out", {24'd0, ir_out}, 32'h0);
        chk("rst_req_valid", {31'd0, req_valid}, 32'h0);
        rst_n = 1;
        @(negedge tck);

        // status after reset
        scan(8'h04, 32'h0, d);
        chk("status_after_rst", d, 32'h0);

        // bypass: one-bit delay line starting from 0
        scan(8'hFF, 32'h0000_00A5, d);
        chk("bypass", d, 32'h0000_014A);

        // write transaction
        scan(8'h01, 32'h0000_1000, d);
        n_pulse = 0; n_vcyc = 0;
        scan(8'h02, 32'hDEAD_BEEF, d);
        wait_idle();
        chk("wr_pulses", n_pulse, 1);
        chk("wr_we", {31'd0, seen_we}, 32'd1);
        chk("wr_addr", seen_addr, 32'h0000_1000);
        chk("wr_wdata", seen_wdata, 32'hDEAD_BEEF);
        chk("wr_busy_clr", {24'd0, ir_out}, 32'h0);

        // pipelined reads
        rsp_data_v = 32'hCAFE_F00D;
        scan(8'h03, 32'h0, d);
        wait_idle();
        rsp_data_v = 32'h1111_2222;
        scan(8'h03, 32'h0, d);
        chk("read_result", d, 32'hCAFE_F00D);
        wait_idle();

        // stalled request, then overrun in the response wait
        ready_lat = 10; rsp_lat = 60;
        n_pulse = 0; n_vcyc = 0;
        scan(8'h02, 32'h1234_5678, d);
        scan(8'h02, 32'h8765_4321, d);
        wait_idle();
        chk("stall_pulses", n_pulse, 1);
        chk("stall_cycles", n_vcyc, 11);
        chk("stall_wdata", seen_wdata, 32'h1234_5678);
        chk("ovr_ir_out", {24'd0, ir_out}, 32'h4);
        scan(8'h04, 32'h1, d);
        chk("ovr_status", d, 32'h4);
        chk("ovr_cleared", {24'd0, ir_out}, 32'h0);
        ready_lat = 0; rsp_lat = 3;

        // error response on a read
        rsp_data_v = 32'hBAD0_BAD0; rsp_err_v = 1;
        scan(8'h03, 32'h0, d);
        wait_idle();
        rsp_err_v = 0;
        scan(8'h04, 32'h0, d);
        chk("err_status", d, 32'h2);
        chk("err_ir_out", {24'd0, ir_out}, 32'h2);
        scan(8'h03, 32'h0, d);
        chk("err_rdata", d, 32'hBAD0_BAD0);
        wait_idle();
        scan(8'h04, 32'h1, d);
        chk("err_cleared", {24'd0, ir_out}, 32'h0);

        // top-of-space read and address after it
        scan(8'h01, 32'hFFFF_FFFC, d);
        scan(8'h03, 32'h0, d);
        wait_idle();
        scan(8'h01, 32'h0, d);
`ifdef VJTAG_ADDR_AUTOINC_EN
        chk("addr_wrap", d, 32'h0);
`else
        chk("addr_hold", d, 32'hFFFF_FFFC);
`endif

        // reset while a request is offered
        bus_en = 0; req_ready = 0; rsp_valid = 0;
        scan(8'h02, 32'h5555_AAAA, d);
        chk("pre_rst_valid", {31'd0, req_valid}, 32'd1);
        rst_n = 0; @(negedge tck);
        chk("mid_rst_valid", {31'd0, req_valid}, 32'd0);
        chk("mid_rst_ir", {24'd0, ir_out}, 32'h0);
        rst_n = 1; @(negedge tck);
        rsp_valid = 1; rsp_err = 1; rsp_rdata = 32'hFFFF_FFFF;
        @(negedge tck);
        rsp_valid = 0; rsp_err = 0;
        @(negedge tck);
        chk("late_rsp_ir", {24'd0, ir_out}, 32'h0);
        scan(8'h04, 32'h0, d);
        chk("late_rsp_status", d, 32'h0);
        scan(8'h03, 32'h0, d);
        chk("late_rsp_rdata", d, 32'h0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
